// File: rtl/fir_pair_packer_if.sv
// Handshake bundle between the sample source, the pair packer and the 2-parallel FIR.
// master: drives samples in and consumes pairs out; slave: the packer itself.
interface fir_pair_packer_if #(
  parameter int AW = 2
);
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x2k;
  logic signed [15:0] x2k_1;
  logic [AW:0]        level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, x2k, x2k_1, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, x2k, x2k_1, level
  );
endinterface

// File: rtl/fir_pair_packer.sv
// Serial-to-pair packer feeding the 2-parallel FIR through a DEPTH-pair FIFO.
// Optional FIR_PACKER_FLUSH_EN adds a flush pulse that zero-pads a trailing odd sample.
//
// state   | meaning
// PH_EVEN | waiting for x[2k]; accepted sample goes to hold
// PH_ODD  | waiting for x[2k+1]; accepted sample completes a pair and is pushed
module fir_pair_packer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic clk,
  input logic rst,
`ifdef FIR_PACKER_FLUSH_EN
  input logic flush,
`endif
  fir_pair_packer_if.slave bus
);

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  phase_t             phase;
  phase_t             phase_nxt;
  logic signed [15:0] hold;
  logic [31:0]        mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        lvl;
  logic [31:0]        head;

  logic               full;
  logic               not_empty;
  logic               in_ready_c;
  logic               accept;
  logic               push;
  logic               pop;
  logic [31:0]        push_data;
  logic               flush_push;

  assign full      = (lvl == LVL_FULL);
  assign not_empty = (lvl != '0);
  assign pop       = not_empty & bus.out_ready;

`ifdef FIR_PACKER_FLUSH_EN
  logic flush_pend;

  // A pending flush waits out a full FIFO rather than dropping the half pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end else if (flush_pend && (phase == PH_EVEN || !full)) begin
      flush_pend <= 1'b0;
    end
  end

  assign flush_push = flush_pend & (phase == PH_ODD) & ~full;
`else
  assign flush_push = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_EVEN;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_EVEN: if (accept) phase_nxt = PH_ODD;
      PH_ODD:  if (accept || flush_push) phase_nxt = PH_EVEN;
      default: phase_nxt = PH_EVEN;
    endcase
  end

  // in_ready depends only on registered state, never on out_ready.
  always_comb begin
    in_ready_c = 1'b0;
    push       = 1'b0;
    push_data  = {hold, bus.in_data};
    case (phase)
      PH_EVEN: in_ready_c = 1'b1;
      PH_ODD:  in_ready_c = ~full;
      default: in_ready_c = 1'b0;
    endcase
`ifdef FIR_PACKER_FLUSH_EN
    if (flush_pend) in_ready_c = 1'b0;
`endif
    accept = bus.in_valid & in_ready_c;
    if (phase == PH_ODD && accept) push = 1'b1;
    if (flush_push) begin
      push      = 1'b1;
      push_data = {hold, 16'sd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (accept && phase == PH_EVEN) begin
      hold <= bus.in_data;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  assign head          = mem[rptr];
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = not_empty;
  assign bus.x2k       = not_empty ? head[31:16] : 16'sd0;
  assign bus.x2k_1     = not_empty ? head[15:0]  : 16'sd0;
  assign bus.level     = lvl;

  a_level_bound: assert property (@(posedge clk) disable iff (rst) lvl <= LVL_FULL);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (not_empty && !bus.out_ready) |=> (not_empty && $stable(head)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_fir_pair_packer.sv
// Scoreboard bench for fir_pair_packer: driver queues expected pairs, negedge monitor checks them.
module tb_fir_pair_packer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef FIR_PACKER_FLUSH_EN
  logic flush = 1'b0;
`endif

  fir_pair_packer_if #(.AW(AW)) bus ();

  fir_pair_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef FIR_PACKER_FLUSH_EN
    .flush(flush),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          ov_cycles = 0;
  logic [31:0] exp_q[$];
  bit          tb_phase = 1'b0;
  logic [15:0] tb_hold = '0;
  bit          lat_pend = 1'b0;
  bit          rand_ready_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pairs are compared in the cycle they are consumed.
  always @(negedge clk) begin
    if (!rst) begin
      if (lat_pend) begin
        chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
        lat_pend = 1'b0;
      end
      if (bus.out_valid) ov_cycles++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pair: got %h expected no pair", {bus.x2k, bus.x2k_1});
        end else begin
          chk("pair", {bus.x2k, bus.x2k_1}, exp_q.pop_front());
        end
      end else if (!bus.out_valid) begin
        chk("idle_zero", {bus.x2k, bus.x2k_1}, 32'd0);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [15:0] s);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = s;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (tb_phase) begin
      exp_q.push_back({tb_hold, s});
      lat_pend = 1'b1;
    end else begin
      tb_hold = s;
    end
    tb_phase = ~tb_phase;
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (bus.level != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_level", 32'(bus.level), 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] full_vals [8];
    logic [15:0] ev;
    logic [15:0] od;
    int          gap;
    full_vals = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF,
                  16'h1234, 16'hEDCC, 16'h0000, 16'h7FFF};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Power-on reset
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_level",     32'(bus.level), 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("rst_data",      {bus.x2k, bus.x2k_1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-stream with two pairs stored and a half pair in hold
    send(16'd11); send(16'd12); send(16'd5); send(16'hFFFD); send(16'd99);
    @(negedge clk);
    chk("pre_rst_level", 32'(bus.level), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_level",     32'(bus.level), 32'd0);
    chk("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_data",      {bus.x2k, bus.x2k_1}, 32'd0);
    exp_q.delete();
    tb_phase = 1'b0;
    lat_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic pack, consumer always ready: first pair must be (1,2)
    bus.out_ready = 1'b1;
    ov_cycles = 0;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("basic_ov_cycles", 32'(ov_cycles), 32'd2);
    chk("basic_level", 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;

    // Full backpressure
    foreach (full_vals[i]) send(full_vals[i]);
    @(negedge clk);
    chk("full_level", 32'(bus.level), 32'd4);
    chk("full_in_ready_even", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(16'h5555);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h6666;
    @(negedge clk);
    chk("full_in_ready_odd", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("full_no_comb_path", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(16'h6666);
    @(negedge clk);
    chk("full_refill_level", 32'(bus.level), 32'd4);
    @(posedge clk);
    #1;
    drain();

    // Simultaneous push and pop at level 2, wrapping pointers many times
    send(16'h0A01); send(16'h0A02); send(16'h0A03); send(16'h0A04);
    for (int i = 0; i < 20; i++) begin
      ev = 16'(16'h1000 + i);
      od = 16'(16'hF000 - i);
      bus.out_ready = 1'b0;
      send(ev);
      bus.out_ready = 1'b1;
      send(od);
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("simul_level", 32'(bus.level), 32'd2);
      @(posedge clk);
      #1;
    end
    drain();

    // Random valid gaps and random consumer stalls
    rand_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send(16'(i * 37) ^ 16'hA5A5);
    end
    rand_ready_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    drain();

`ifdef FIR_PACKER_FLUSH_EN
    // Flush pads the trailing odd sample with zero
    send(16'd7); send(16'd9); send(16'hFFFF);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_q.push_back({16'hFFFF, 16'h0000});
    tb_phase = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("flush_level", 32'(bus.level), 32'd2);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("flush_even_level", 32'(bus.level), 32'd2);
    chk("flush_even_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    drain();
`else
    // Without flush a trailing odd sample waits in hold for its partner
    send(16'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_level", 32'(bus.level), 32'd0);
    @(posedge clk);
    #1;
    send(16'd9);
    @(negedge clk);
    chk("hold_pair_level", 32'(bus.level), 32'd1);
    @(posedge clk);
    #1;
    drain();
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
